pb_tile_lookup: RTL and testbench

PB_TILE_LOOKUP -- requirements
Module: pb_tile_lookup

---
 rtl/pb_tile_lookup.sv | 197 +++++++++++++++++++
 tb/tb_pb_tile_lookup.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_tile_lookup.sv
// pb_tile_lookup: programmable address-range to mesh-tile decoder.
//
// A table of NumRules rules maps address ranges [start, end) onto (x, y)
// tile coordinates. Lookups travel through a two-stage pipeline: stage 1
// holds the address and compares it against every rule, and the output
// stage registers the winning (lowest-index) rule. A registered bitmap
// reports which tiles are targeted by at least one valid rule.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cfg_req_i / cfg_gnt_o     rule write request / accepted this cycle
//   cfg_idx_i                 rule index to write
//   cfg_valid_i, cfg_start_i, cfg_end_i, cfg_x_i, cfg_y_i   rule contents
//   in_valid_i / in_ready_o   lookup request handshake
//   in_addr_i                 address to decode
//   out_valid_o / out_ready_i lookup result handshake
//   out_hit_o, out_x_o, out_y_o, out_rule_o   result (all zero on a miss)
//   tile_present_o            tile presence bitmap, bit x*MeshY+y
//   stat_hit_o, stat_miss_o   delivered hit/miss counters, saturating
//                             (only with PB_TILE_LOOKUP_STATS_EN defined)
//
// Build option: define PB_TILE_LOOKUP_STATS_EN to add the statistics ports.
module pb_tile_lookup #(
    parameter int MeshX     = 4,
    parameter int MeshY     = 4,
    parameter int NumRules  = 16,
    parameter int AddrWidth = 48,
    localparam int XW = (MeshX > 1) ? $clog2(MeshX) : 1,
    localparam int YW = (MeshY > 1) ? $clog2(MeshY) : 1,
    localparam int IW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_req_i,
    output logic                   cfg_gnt_o,
    input  logic [IW-1:0]          cfg_idx_i,
    input  logic                   cfg_valid_i,
    input  logic [AddrWidth-1:0]   cfg_start_i,
    input  logic [AddrWidth-1:0]   cfg_end_i,
    input  logic [XW-1:0]          cfg_x_i,
    input  logic [YW-1:0]          cfg_y_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AddrWidth-1:0]   in_addr_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_hit_o,
    output logic [XW-1:0]          out_x_o,
    output logic [YW-1:0]          out_y_o,
    output logic [IW-1:0]          out_rule_o,
    output logic [MeshX*MeshY-1:0] tile_present_o
`ifdef PB_TILE_LOOKUP_STATS_EN
    ,
    output logic [31:0]            stat_hit_o,
    output logic [31:0]            stat_miss_o
`endif
);

    localparam logic [XW:0] MeshXL = MeshX[XW:0];
    localparam logic [YW:0] MeshYL = MeshY[YW:0];

    // Rule table
    logic [NumRules-1:0]  rule_valid;
    logic [AddrWidth-1:0] rule_start [NumRules];
    logic [AddrWidth-1:0] rule_end   [NumRules];
    logic [XW-1:0]        rule_x     [NumRules];
    logic [YW-1:0]        rule_y     [NumRules];

    // Pipeline state
    logic                 s1_valid;
    logic [AddrWidth-1:0] s1_addr;
    logic                 out_advance;
    logic                 accept;
    logic                 coord_ok;

    logic [NumRules-1:0]  rule_hit;
    logic                 hit_any;
    logic                 found;
    logic [IW-1:0]        hit_idx;

    logic [MeshX*MeshY-1:0] present_next;

    // Handshakes. Writes are only granted with stage 1 empty, so the rule
    // table never changes underneath an address being compared.
    assign out_advance = !out_valid_o || out_ready_i;
    assign cfg_gnt_o   = rst_ni && cfg_req_i && !s1_valid;
    assign in_ready_o  = (!s1_valid || out_advance) && !cfg_gnt_o;
    assign accept      = in_valid_i && in_ready_o;

    // Out-of-mesh coordinates are stored but the rule is forced invalid.
    assign coord_ok = ({1'b0, cfg_x_i} < MeshXL) && ({1'b0, cfg_y_i} < MeshYL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rule_valid <= '0;
            for (int unsigned i = 0; i < NumRules; i++) begin
                rule_start[i] <= '0;
                rule_end[i]   <= '0;
                rule_x[i]     <= '0;
                rule_y[i]     <= '0;
            end
        end else if (cfg_gnt_o) begin
            rule_valid[cfg_idx_i] <= cfg_valid_i && coord_ok;
            rule_start[cfg_idx_i] <= cfg_start_i;
            rule_end[cfg_idx_i]   <= cfg_end_i;
            rule_x[cfg_idx_i]     <= cfg_x_i;
            rule_y[cfg_idx_i]     <= cfg_y_i;
        end
    end

    // Stage 1: address register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_addr  <= in_addr_i;
        end else if (out_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Range compare; start >= end can never satisfy both bounds.
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
        assign rule_hit[gi] = rule_valid[gi] &&
                              (s1_addr >= rule_start[gi]) &&
                              (s1_addr <  rule_end[gi]);
    end

    // Lowest matching index wins.
    always_comb begin
        found   = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NumRules; i++) begin
            if (rule_hit[i] && !found) begin
                found   = 1'b1;
                hit_idx = IW'(i);
            end
        end
        hit_any = found;
    end

    // Output stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_hit_o   <= 1'b0;
            out_x_o     <= '0;
            out_y_o     <= '0;
            out_rule_o  <= '0;
        end else if (out_advance) begin
            out_valid_o <= s1_valid;
            out_hit_o   <= s1_valid && hit_any;
            out_x_o     <= (s1_valid && hit_any) ? rule_x[hit_idx] : '0;
            out_y_o     <= (s1_valid && hit_any) ? rule_y[hit_idx] : '0;
            out_rule_o  <= (s1_valid && hit_any) ? hit_idx : '0;
        end
    end

    // Presence bitmap, rebuilt from the table and registered.
    for (genvar gx = 0; gx < MeshX; gx++) begin : g_px
        for (genvar gy = 0; gy < MeshY; gy++) begin : g_py
            logic [NumRules-1:0] tile_match;
            for (genvar gr = 0; gr < NumRules; gr++) begin : g_pr
                assign tile_match[gr] = rule_valid[gr] &&
                                        (rule_x[gr] == XW'(gx)) &&
                                        (rule_y[gr] == YW'(gy));
            end
            assign present_next[gx*MeshY+gy] = |tile_match;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tile_present_o <= '0;
        end else begin
            tile_present_o <= present_next;
        end
    end

`ifdef PB_TILE_LOOKUP_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_hit_o  <= '0;
            stat_miss_o <= '0;
        end else if (out_valid_o && out_ready_i) begin
            if (out_hit_o) begin
                if (stat_hit_o != '1) stat_hit_o <= stat_hit_o + 32'd1;
            end else begin
                if (stat_miss_o != '1) stat_miss_o <= stat_miss_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pb_tile_lookup.sv
// Directed bench for pb_tile_lookup with default parameters
// (4x4 mesh, 16 rules, 48-bit addresses).
module tb_pb_tile_lookup;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_req_i;
    logic        cfg_gnt_o;
    logic [3:0]  cfg_idx_i;
    logic        cfg_valid_i;
    logic [47:0] cfg_start_i;
    logic [47:0] cfg_end_i;
    logic [1:0]  cfg_x_i;
    logic [1:0]  cfg_y_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [47:0] in_addr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_hit_o;
    logic [1:0]  out_x_o;
    logic [1:0]  out_y_o;
    logic [3:0]  out_rule_o;
    logic [15:0] tile_present_o;
`ifdef PB_TILE_LOOKUP_STATS_EN
    logic [31:0] stat_hit_o;
    logic [31:0] stat_miss_o;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    pb_tile_lookup #(
        .MeshX(4), .MeshY(4), .NumRules(16), .AddrWidth(48)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_idx_i(cfg_idx_i),
        .cfg_valid_i(cfg_valid_i), .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i),
        .cfg_x_i(cfg_x_i), .cfg_y_i(cfg_y_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_addr_i(in_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_hit_o(out_hit_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
        .out_rule_o(out_rule_o), .tile_present_o(tile_present_o)
`ifdef PB_TILE_LOOKUP_STATS_EN
        , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tally(input logic hit);
        if (hit) exp_hits++;
        else exp_misses++;
    endtask

    // Called at a negedge; returns at a negedge with the pipeline drained.
    task automatic cfg_write(input logic [3:0] idx, input logic v, input logic [47:0] s,
                             input logic [47:0] e, input logic [1:0] x, input logic [1:0] y);
        cfg_req_i = 1'b1; cfg_idx_i = idx; cfg_valid_i = v;
        cfg_start_i = s; cfg_end_i = e; cfg_x_i = x; cfg_y_i = y;
        #1 check("cfg_gnt", cfg_gnt_o, 1);
        @(negedge clk_i);
        cfg_req_i = 1'b0;
    endtask

    task automatic do_lookup(input string tag, input logic [47:0] a, input logic eh,
                             input logic [1:0] ex, input logic [1:0] ey, input logic [3:0] er);
        in_valid_i = 1'b1; in_addr_i = a; out_ready_i = 1'b1;
        #1 check({tag, "_ready"}, in_ready_o, 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1 check({tag, "_lat1"}, out_valid_o, 0);
        @(negedge clk_i);
        #1;
        check({tag, "_valid"}, out_valid_o, 1);
        check({tag, "_hit"},   out_hit_o, eh);
        check({tag, "_x"},     out_x_o, ex);
        check({tag, "_y"},     out_y_o, ey);
        check({tag, "_rule"},  out_rule_o, er);
        tally(eh);
        @(negedge clk_i);
        #1 check({tag, "_drain"}, out_valid_o, 0);
    endtask

    // Stream vectors: {hit, x[1:0], y[1:0], rule[3:0]}
    logic [47:0] st_addr [8];
    logic [8:0]  st_exp  [8];

    initial begin
        int sent;
        int recv;
        int done_cyc;
        logic stalled;
        logic [8:0] held;
        logic [8:0] obs;

        st_addr[0] = 48'h1700; st_exp[0] = {1'b1, 2'd2, 2'd3, 4'd3};
        st_addr[1] = 48'h1900; st_exp[1] = {1'b1, 2'd3, 2'd1, 4'd5};
        st_addr[2] = 48'h0100; st_exp[2] = 9'd0;
        st_addr[3] = 48'h2FFF; st_exp[3] = {1'b1, 2'd3, 2'd1, 4'd5};
        st_addr[4] = 48'h3000; st_exp[4] = 9'd0;
        st_addr[5] = 48'h18FF; st_exp[5] = {1'b1, 2'd2, 2'd3, 4'd3};
        st_addr[6] = 48'h5000; st_exp[6] = 9'd0;
        st_addr[7] = 48'h1800; st_exp[7] = {1'b1, 2'd2, 2'd3, 4'd3};

        // Reset state, with a write request pending during reset
        rst_ni = 1'b0; cfg_req_i = 1'b1; cfg_idx_i = '0; cfg_valid_i = 1'b1;
        cfg_start_i = '0; cfg_end_i = '0; cfg_x_i = '0; cfg_y_i = '0;
        in_valid_i = 1'b0; in_addr_i = '0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_gnt", cfg_gnt_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_fields", {out_hit_o, out_x_o, out_y_o, out_rule_o}, 0);
        check("rst_present", tile_present_o, 0);
        cfg_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 check("rst_in_ready", in_ready_o, 1);
        @(negedge clk_i);

        // Rule 0 and the lagging presence bitmap
        cfg_write(4'd0, 1'b1, 48'h1000, 48'h2000, 2'd1, 2'd2);
        #1 check("present_lag", tile_present_o, 16'h0000);
        @(negedge clk_i);
        #1 check("present_r0", tile_present_o, 16'h0040);
        do_lookup("lk1800", 48'h1800, 1'b1, 2'd1, 2'd2, 4'd0);
        do_lookup("lk1fff", 48'h1FFF, 1'b1, 2'd1, 2'd2, 4'd0);
        do_lookup("lk1000", 48'h1000, 1'b1, 2'd1, 2'd2, 4'd0);
        do_lookup("lk2000", 48'h2000, 1'b0, 2'd0, 2'd0, 4'd0);
        do_lookup("lk0fff", 48'h0FFF, 1'b0, 2'd0, 2'd0, 4'd0);

        // Overlapping rules 3 and 5, rule 0 removed, empty range in rule 7
        cfg_write(4'd0, 1'b0, 48'h1000, 48'h2000, 2'd1, 2'd2);
        cfg_write(4'd3, 1'b1, 48'h1700, 48'h1900, 2'd2, 2'd3);
        cfg_write(4'd5, 1'b1, 48'h1800, 48'h3000, 2'd3, 2'd1);
        cfg_write(4'd7, 1'b1, 48'h5000, 48'h5000, 2'd0, 2'd0);
        do_lookup("prio", 48'h1800, 1'b1, 2'd2, 2'd3, 4'd3);
        do_lookup("r5", 48'h2800, 1'b1, 2'd3, 2'd1, 4'd5);
        do_lookup("empty", 48'h5000, 1'b0, 2'd0, 2'd0, 4'd0);
        check("present_ovl", tile_present_o, 16'h2801);

        // Streaming with a 3-cycle output stall
        sent = 0; recv = 0; done_cyc = -1; stalled = 1'b0; held = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            out_ready_i = !(c >= 3 && c <= 5);
            in_valid_i  = (sent < 8);
            in_addr_i   = (sent < 8) ? st_addr[sent] : 48'h0;
            #1;
            obs = {out_hit_o, out_x_o, out_y_o, out_rule_o};
            if (out_valid_o) begin
                if (stalled) check("stream_hold", obs, held);
                if (out_ready_i) begin
                    check("stream_data", obs, st_exp[recv]);
                    tally(st_exp[recv][8]);
                    recv++;
                    if (recv == 8) done_cyc = c;
                end
            end
            stalled = out_valid_o && !out_ready_i;
            held = obs;
            if (in_valid_i && in_ready_o) sent++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        check("stream_sent", sent, 8);
        check("stream_recv", recv, 8);
        check("stream_done_cycle", done_cyc, 12);
        #1 check("stream_no_extra", out_valid_o, 0);
        @(negedge clk_i);

        // Config write blocked while stage 1 is occupied
        in_valid_i = 1'b1; in_addr_i = 48'h1700;
        #1 check("col_ready", in_ready_o, 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        cfg_req_i = 1'b1; cfg_idx_i = 4'd1; cfg_valid_i = 1'b1;
        cfg_start_i = 48'h6000; cfg_end_i = 48'h7000; cfg_x_i = 2'd1; cfg_y_i = 2'd1;
        #1 check("col_gnt_blocked", cfg_gnt_o, 0);
        @(negedge clk_i);
        in_valid_i = 1'b1; in_addr_i = 48'h6800;
        #1;
        check("col_gnt_free", cfg_gnt_o, 1);
        check("col_wr_priority", in_ready_o, 0);
        check("col_out", {out_valid_o, out_hit_o, out_x_o, out_y_o, out_rule_o},
              {1'b1, 1'b1, 2'd2, 2'd3, 4'd3});
        tally(1'b1);
        @(negedge clk_i);
        cfg_req_i = 1'b0; in_valid_i = 1'b0;
        #1 check("col_not_taken", out_valid_o, 0);
        do_lookup("new_rule", 48'h6800, 1'b1, 2'd1, 2'd1, 4'd1);
        check("present_r1", tile_present_o, 16'h2821);
`ifdef PB_TILE_LOOKUP_STATS_EN
        check("stat_hit", stat_hit_o, exp_hits);
        check("stat_miss", stat_miss_o, exp_misses);
`endif

        // Reset with two lookups in flight
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_addr_i = 48'h1700;
        @(negedge clk_i);
        in_addr_i = 48'h1800;
        #1 check("fl_ready2", in_ready_o, 1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1 check("fl_pending", out_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("fl_rst_valid", out_valid_o, 0);
        check("fl_rst_present", tile_present_o, 0);
        exp_hits = 0; exp_misses = 0;
        @(negedge clk_i);
        rst_ni = 1'b1; out_ready_i = 1'b1;
        #1 check("fl_ready_after", in_ready_o, 1);
        @(negedge clk_i);
        #1 check("fl_no_ghost", out_valid_o, 0);
        do_lookup("post_rst_a", 48'h1800, 1'b0, 2'd0, 2'd0, 4'd0);
        do_lookup("post_rst_b", 48'h6800, 1'b0, 2'd0, 2'd0, 4'd0);
        check("post_rst_present", tile_present_o, 0);
`ifdef PB_TILE_LOOKUP_STATS_EN
        check("stat_hit_rst", stat_hit_o, exp_hits);
        check("stat_miss_rst", stat_miss_o, exp_misses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
